// File: rtl/pkt_deframer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pkt_deframer_pkg
// Description : Shared types and constants for the packet deframer: FSM state
//               enumeration, header field positions, skid-buffer depth and
//               the beat record carried through the skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package pkt_deframer_pkg;

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_PARITY  = 2'd2
    } state_t;

    // Header byte layout: [7:2] payload length, [1:0] destination.
    localparam int c_LEN_MSB    = 7;
    localparam int c_LEN_LSB    = 2;
    localparam int c_DEST_MSB   = 1;
    localparam int c_DEST_LSB   = 0;
    localparam int c_LEN_W      = c_LEN_MSB - c_LEN_LSB + 1;
    localparam int c_DEST_W     = c_DEST_MSB - c_DEST_LSB + 1;

    localparam int c_SKID_DEPTH = 2;
    localparam int c_OCC_W      = $clog2(c_SKID_DEPTH + 1);

    typedef struct packed {
        logic [7:0]          data;
        logic                sof;
        logic                eof;
        logic                err;
        logic [c_DEST_W-1:0] dest;
    } beat_t;

endpackage
`default_nettype wire

// File: rtl/pkt_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : pkt_skid_buf
// Description : Two-entry in-order beat buffer with valid/ready on both sides.
//               Slot 0 is always the head; a simultaneous push and pop keeps
//               occupancy unchanged and preserves order.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               i_push_valid/o_push_ready/i_push_beat - write side
//               o_pop_valid/i_pop_ready/o_pop_beat    - read side
//               o_occupancy              - number of entries held
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_skid_buf
    import pkt_deframer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push_valid,
    output logic               o_push_ready,
    input  beat_t              i_push_beat,
    output logic               o_pop_valid,
    input  logic               i_pop_ready,
    output beat_t              o_pop_beat,
    output logic [c_OCC_W-1:0] o_occupancy
);

    logic [c_OCC_W-1:0] r_count;
    beat_t              r_slot0;
    beat_t              r_slot1;
    logic               w_push;
    logic               w_pop;

    assign o_push_ready = (r_count < c_OCC_W'(c_SKID_DEPTH));
    assign o_pop_valid  = (r_count != '0);
    assign o_pop_beat   = r_slot0;
    assign o_occupancy  = r_count;

    assign w_push = i_push_valid && o_push_ready;
    assign w_pop  = o_pop_valid && i_pop_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == '0) r_slot0 <= i_push_beat;
                    else               r_slot1 <= i_push_beat;
                    r_count <= r_count + c_OCC_W'(1);
                end
                2'b01: begin
                    r_slot0 <= r_slot1;
                    r_count <= r_count - c_OCC_W'(1);
                end
                2'b11: begin
                    // Head leaves while a new beat arrives: the new beat lands
                    // behind whatever remains.
                    if (r_count == c_OCC_W'(1)) begin
                        r_slot0 <= i_push_beat;
                    end else begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= i_push_beat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pkt_deframer.sv
`default_nettype none
// ============================================================================
// Module      : pkt_deframer
// Description : Reads header/payload/parity frames from an 8-bit FIFO with
//               one-cycle read latency, tags each byte as a downstream beat
//               (sof on header, eof + parity error on parity byte, dest held
//               across the packet) and counts packets and parity errors.
// Ports       : clock, reset             - clock, synchronous active-high reset
//               fifo_empty/fifo_data/read_enb - upstream FIFO
//               out_ready/out_valid/out_data/out_sof/out_eof/out_dest/out_err
//                                        - downstream beat interface
//               pkt_count/err_count      - saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_deframer
    import pkt_deframer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                fifo_empty,
    input  logic [7:0]          fifo_data,
    output logic                read_enb,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [7:0]          out_data,
    output logic                out_sof,
    output logic                out_eof,
    output logic [c_DEST_W-1:0] out_dest,
    output logic                out_err,
    output logic [CNT_W-1:0]    pkt_count,
    output logic [CNT_W-1:0]    err_count
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_LEN_W-1:0]   r_len;
    logic [c_LEN_W-1:0]   w_len_nxt;
    logic [7:0]           r_xor;
    logic [7:0]           w_xor_nxt;
    logic [c_DEST_W-1:0]  r_dest;
    logic [c_DEST_W-1:0]  w_dest_nxt;
    logic                 r_inflight;
    logic                 w_cap;
    logic                 w_push_ready;
    beat_t                w_beat;
    beat_t                w_head;
    logic [c_OCC_W-1:0]   w_occ;
    logic [c_OCC_W:0]     w_fill;
    logic                 w_eof_xfer;
    logic [CNT_W-1:0]     r_pkt_count;
    logic [CNT_W-1:0]     r_err_count;

    // A read is only issued if the byte it returns next cycle is guaranteed
    // a skid slot, so occupancy plus any outstanding read must leave room.
    assign w_fill   = {1'b0, w_occ} + {{c_OCC_W{1'b0}}, r_inflight};
    assign read_enb = !reset && !fifo_empty && (w_fill < (c_OCC_W + 1)'(c_SKID_DEPTH));

    // fifo_data is valid the cycle after an accepted read.
    assign w_cap = r_inflight && w_push_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_HEADER;
            r_len      <= '0;
            r_xor      <= '0;
            r_dest     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_xor      <= w_xor_nxt;
            r_dest     <= w_dest_nxt;
            r_inflight <= read_enb;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_xor_nxt   = r_xor;
        w_dest_nxt  = r_dest;
        w_beat      = '0;
        w_beat.data = fifo_data;
        w_beat.dest = r_dest;
        if (w_cap) begin
            case (r_state)
                ST_HEADER: begin
                    w_beat.sof  = 1'b1;
                    w_beat.dest = fifo_data[c_DEST_MSB:c_DEST_LSB];
                    w_dest_nxt  = fifo_data[c_DEST_MSB:c_DEST_LSB];
                    w_len_nxt   = fifo_data[c_LEN_MSB:c_LEN_LSB];
                    w_xor_nxt   = fifo_data;
                    w_state_nxt = (fifo_data[c_LEN_MSB:c_LEN_LSB] == '0) ? ST_PARITY : ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    w_xor_nxt = r_xor ^ fifo_data;
                    w_len_nxt = r_len - c_LEN_W'(1);
                    if (r_len == c_LEN_W'(1)) w_state_nxt = ST_PARITY;
                end
                ST_PARITY: begin
                    w_beat.eof  = 1'b1;
                    w_beat.err  = |(r_xor ^ fifo_data);
                    w_state_nxt = ST_HEADER;
                end
                default: w_state_nxt = ST_HEADER;
            endcase
        end
    end

    pkt_skid_buf u_skid (
        .clk          (clock),
        .rst          (reset),
        .i_push_valid (w_cap),
        .o_push_ready (w_push_ready),
        .i_push_beat  (w_beat),
        .o_pop_valid  (out_valid),
        .i_pop_ready  (out_ready),
        .o_pop_beat   (w_head),
        .o_occupancy  (w_occ)
    );

    assign out_data = w_head.data;
    assign out_sof  = w_head.sof;
    assign out_eof  = w_head.eof;
    assign out_err  = w_head.err;
    assign out_dest = w_head.dest;

    assign w_eof_xfer = out_valid && out_ready && out_eof;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pkt_count <= '0;
            r_err_count <= '0;
        end else if (w_eof_xfer) begin
            if (r_pkt_count != '1)            r_pkt_count <= r_pkt_count + CNT_W'(1);
            if (out_err && r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign pkt_count = r_pkt_count;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_pkt_deframer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_deframer
// Description : Self-checking bench for pkt_deframer. A FIFO model feeds
//               directed frames; expected beats are derived per whole frame
//               and checked each cycle alongside counters and hold stability.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_deframer;

    localparam int CNT_W = 3;
    localparam int c_CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       err;
        logic [1:0] dest;
    } exp_beat_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             fifo_empty;
    logic [7:0]       fifo_data;
    logic             read_enb;
    logic             out_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_sof;
    logic             out_eof;
    logic [1:0]       out_dest;
    logic             out_err;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] err_count;

    always #5 clock = ~clock;

    pkt_deframer #(.CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .read_enb   (read_enb),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .out_dest   (out_dest),
        .out_err    (out_err),
        .pkt_count  (pkt_count),
        .err_count  (err_count)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] pkt[$];
    exp_beat_t  exp_q[$];
    exp_beat_t  obs_q[$];
    bit         hold_empty = 1'b0;
    bit         rd_pend = 1'b0;
    int         rd_pulses = 0;
    int         mdl_pkt = 0;
    int         mdl_err = 0;
    bit         held = 1'b0;
    exp_beat_t  held_beat;
    exp_beat_t  cur;
    exp_beat_t  e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- upstream FIFO model (1-cycle read latency) ----------
    always @(negedge clock) begin
        check("read_while_empty", {31'd0, read_enb & fifo_empty}, 32'd0);
        rd_pend = read_enb;
        if (read_enb) rd_pulses++;
    end

    always @(posedge clock) begin
        if (rd_pend && fifo_q.size() > 0) begin
            fifo_data  <= fifo_q.pop_front();
            fifo_empty <= hold_empty || (fifo_q.size() == 0);
        end
    end

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_empty = hold_empty || (fifo_q.size() == 0);
    endtask

    // Expected beats for the frame in pkt: header tags sof and fixes dest for
    // the whole frame; the final byte is eof, erroneous if the XOR of every
    // byte (header, payload, parity) is non-zero.
    task automatic expect_pkt(input bit partial);
        logic [7:0] x;
        logic [7:0] h;
        exp_beat_t  b;
        x = 8'h00;
        h = pkt[0];
        foreach (pkt[i]) x ^= pkt[i];
        for (int i = 0; i < pkt.size(); i++) begin
            b.data = pkt[i];
            b.sof  = (i == 0);
            b.eof  = !partial && (i == pkt.size() - 1);
            b.err  = b.eof && (x != 8'h00);
            b.dest = h[1:0];
            exp_q.push_back(b);
        end
    endtask

    task automatic send_pkt(input bit partial);
        expect_pkt(partial);
        foreach (pkt[i]) push_byte(pkt[i]);
    endtask

    // ---------------- per-cycle compare ------------------------------------
    always @(negedge clock) begin
        cur = {out_data, out_sof, out_eof, out_err, out_dest};
        if (reset) begin
            mdl_pkt = 0;
            mdl_err = 0;
            held    = 1'b0;
        end else begin
            check("pkt_count", 32'(pkt_count), 32'(mdl_pkt));
            check("err_count", 32'(err_count), 32'(mdl_err));
            if (held) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_beat", 32'(cur), 32'(held_beat));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 32'(cur), 32'(e));
                    obs_q.push_back(cur);
                    if (e.eof) begin
                        if (mdl_pkt < c_CNT_MAX) mdl_pkt++;
                        if (e.err && mdl_err < c_CNT_MAX) mdl_err++;
                    end
                end
            end
            held      = out_valid && !out_ready;
            held_beat = cur;
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 300) begin
            @(posedge clock);
            n++;
        end
        check({name, "_drain"}, {31'd0, n < 300}, 32'd1);
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_fail++;
        summary();
        $fatal(1, "watchdog");
    end

    initial begin : main
        int r0;
        int n;
        reset      = 1'b1;
        out_ready  = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;

        // Reset with data waiting upstream.
        pkt = {8'h09, 8'h63, 8'hAA, 8'hC0};
        send_pkt(1'b0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_read_enb", {31'd0, read_enb}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        reset = 1'b0;

        // Good packet.
        wait_idle("good");
        check("good_nbeats", obs_q.size(), 32'd4);
        check("good_b0", 32'(obs_q[0]), {19'd0, 8'h09, 1'b1, 1'b0, 1'b0, 2'd1});
        check("good_b1", 32'(obs_q[1]), {19'd0, 8'h63, 1'b0, 1'b0, 1'b0, 2'd1});
        check("good_b2", 32'(obs_q[2]), {19'd0, 8'hAA, 1'b0, 1'b0, 1'b0, 2'd1});
        check("good_b3", 32'(obs_q[3]), {19'd0, 8'hC0, 1'b0, 1'b1, 1'b0, 2'd1});
        check("good_pkt_count", 32'(pkt_count), 32'd1);
        obs_q.delete();

        // Zero-length then bad parity, from fresh counters.
        do_reset();
        pkt = {8'h03, 8'h03};
        send_pkt(1'b0);
        pkt = {8'h04, 8'h24, 8'h00};
        send_pkt(1'b0);
        wait_idle("zl_bad");
        check("zl_b0", 32'(obs_q[0]), {19'd0, 8'h03, 1'b1, 1'b0, 1'b0, 2'd3});
        check("zl_b1", 32'(obs_q[1]), {19'd0, 8'h03, 1'b0, 1'b1, 1'b0, 2'd3});
        check("bad_eof", 32'(obs_q[4]), {19'd0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd0});
        check("bad_pkt_count", 32'(pkt_count), 32'd2);
        check("bad_err_count", 32'(err_count), 32'd1);
        obs_q.delete();

        // Backpressure with four bytes queued.
        out_ready = 1'b0;
        r0 = rd_pulses;
        pkt = {8'h0A, 8'h11, 8'h22, 8'h39};
        send_pkt(1'b0);
        repeat (6) @(posedge clock);
        #1;
        check("bp_reads_le2", {31'd0, (rd_pulses - r0) <= 2}, 32'd1);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_head", {24'd0, out_data}, 32'h0A);
        out_ready = 1'b1;
        wait_idle("bp");
        check("bp_nbeats", obs_q.size(), 32'd4);
        check("bp_pkt_count", 32'(pkt_count), 32'd3);
        obs_q.delete();

        // FIFO runs dry mid-packet.
        pkt = {8'h08, 8'h55, 8'h66, 8'h3B};
        expect_pkt(1'b0);
        push_byte(8'h08);
        push_byte(8'h55);
        n = 0;
        while (fifo_q.size() != 0 && n < 50) begin
            @(posedge clock);
            n++;
        end
        #1;
        hold_empty = 1'b1;
        push_byte(8'h66);
        push_byte(8'h3B);
        r0 = rd_pulses;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check("empty_no_read", {31'd0, read_enb}, 32'd0);
        end
        check("empty_pulses", rd_pulses - r0, 32'd0);
        hold_empty = 1'b0;
        fifo_empty = (fifo_q.size() == 0);
        wait_idle("empty");
        check("empty_eof", 32'(obs_q[3]), {19'd0, 8'h3B, 1'b0, 1'b1, 1'b0, 2'd0});
        check("empty_pkt_count", 32'(pkt_count), 32'd4);
        obs_q.delete();

        // Reset mid-packet; next bytes start a fresh frame.
        pkt = {8'h09, 8'h63};
        send_pkt(1'b1);
        wait_idle("partial");
        do_reset();
        pkt = {8'h04, 8'h24, 8'h20};
        send_pkt(1'b0);
        wait_idle("fresh");
        check("fresh_b0", 32'(obs_q[2]), {19'd0, 8'h04, 1'b1, 1'b0, 1'b0, 2'd0});
        check("fresh_eof", 32'(obs_q[4]), {19'd0, 8'h20, 1'b0, 1'b1, 1'b0, 2'd0});
        check("fresh_pkt_count", 32'(pkt_count), 32'd1);
        check("fresh_err_count", 32'(err_count), 32'd0);
        obs_q.delete();

        // Counter saturation: eight more bad zero-length packets.
        for (int i = 0; i < 8; i++) begin
            pkt = {8'h02, 8'h00};
            send_pkt(1'b0);
        end
        wait_idle("sat");
        check("sat_pkt_count", 32'(pkt_count), 32'd7);
        check("sat_err_count", 32'(err_count), 32'd7);

        summary();
        $finish;
    end

endmodule
`default_nettype wire
